// File: rtl/axi_write_slave.sv
// AXI3-style write slave: accepts AW/W bursts into a strobed word memory and
// returns one B response per burst. Debug read port has one cycle of latency.
//   state | meaning
//   IDLE  | waiting for a write address
//   DATA  | consuming W beats of the captured burst
//   RESP  | holding the B response until BREADY
module axi_write_slave #(
    parameter int          buswidth  = 32,
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [3:0]                   AWID,
    input  logic [31:0]                  AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic [1:0]                   AWLOCK,
    input  logic [3:0]                   AWCACHE,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [3:0]                   WID,
    input  logic [buswidth-1:0]          WDATA,
    input  logic [buswidth/8-1:0]        WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [3:0]                   BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
    output logic [buswidth-1:0]          rd_data
);
    localparam int         NB  = buswidth / 8;
    localparam int         LB  = $clog2(NB);
    localparam int         AW  = $clog2(MEM_DEPTH);
    localparam logic [2:0] LB3 = 3'(LB);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t state, state_nxt;

    logic [buswidth-1:0] mem [MEM_DEPTH];

    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic        cfg_err_q;

    logic        aw_hs, w_hs, b_hs;
    logic        cfg_err_in;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] widx;
    logic        last_beat;
    logic        beat_err;
    logic        wen;
    logic [31:0] step, wrap_mask, addr_inc, addr_nxt;
    logic        unused_ok;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;

    assign cfg_err_in = (AWSIZE > LB3) || (AWBURST == 2'b11) ||
                        ((AWBURST == 2'b10) && !(AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));

    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = (addr_q >= BASE_ADDR) && ((offset >> LB) < 32'(MEM_DEPTH));
    assign widx      = offset[LB +: AW];
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = !in_range || (WLAST != last_beat);
    assign wen       = w_hs && in_range && !cfg_err_q && ARESETn;

    // WRAP keeps the bits above the window and wraps the bits inside it
    assign step      = 32'd1 << size_q;
    assign wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
    assign addr_inc  = addr_q + step;

    always_comb begin
        addr_nxt = addr_inc;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_nxt = addr_inc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state   <= IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= 4'd0;
            BRESP   <= 2'b00;
        end else begin
            state   <= state_nxt;
            AWREADY <= (state_nxt == IDLE);
            WREADY  <= (state_nxt == DATA);
            BVALID  <= (state_nxt == RESP);
            if (state == DATA && state_nxt == RESP) begin
                BID   <= id_q;
                BRESP <= (err_q || beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            id_q      <= AWID;
            addr_q    <= AWADDR;
            len_q     <= AWLEN;
            size_q    <= AWSIZE;
            burst_q   <= AWBURST;
            cnt_q     <= 4'd0;
            cfg_err_q <= cfg_err_in;
            err_q     <= cfg_err_in;
        end else if (w_hs) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 4'd1;
            if (beat_err) err_q <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wen) begin
            for (int k = 0; k < NB; k++) begin
                if (WSTRB[k]) mem[widx][8*k +: 8] <= WDATA[8*k +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) rd_data <= '0;
        else          rd_data <= mem[rd_addr];
    end

    assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, WID};

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed vector table, reset-mid-burst sequence
// and randomized bursts checked against a byte-level memory model.
module tb_axi_write_slave;
    localparam int          DEPTH = 64;
    localparam longint      BASE  = 0;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    axi_write_slave #(.buswidth(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    logic [3:0]  b_id;
    logic [31:0] b_addr;
    logic [3:0]  b_len;
    logic [2:0]  b_size;
    logic [1:0]  b_burst;
    logic [31:0] b_data [16];
    logic [3:0]  b_strb [16];
    logic        b_last [16];
    bit          b_gap;
    int          b_bdelay;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] dbase;
        logic [3:0]  strb;
        int          bad_last;
        bit          gap;
        int          bdelay;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within 100 cycles, required one", what);
    endtask

    task automatic set_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] dbase,
                             input logic [3:0] strb, input int bad_last, input bit gap, input int bdelay);
        b_id = id; b_addr = addr; b_len = len; b_size = size; b_burst = burst;
        b_gap = gap; b_bdelay = bdelay;
        for (int i = 0; i < 16; i++) begin
            b_data[i] = dbase + 32'(i);
            b_strb[i] = strb;
            b_last[i] = (i == int'(len)) ^ (i == bad_last);
        end
    endtask

    // Reference: walks the burst's byte addresses arithmetically and updates model_mem
    task automatic model_apply(output logic [1:0] resp);
        longint a, step, window, base, idx;
        bit cfg, err, ok;
        a      = longint'(b_addr);
        step   = longint'(1) << b_size;
        window = (longint'(b_len) + 1) * step;
        cfg = (b_size > 3'd2) || (b_burst == 2'b11) ||
              (b_burst == 2'b10 && !(b_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
        err = cfg;
        for (int i = 0; i <= int'(b_len); i++) begin
            idx = (a - BASE) / 4;
            ok  = (a >= BASE) && (idx < DEPTH);
            if (!ok) err = 1;
            else if (!cfg) begin
                for (int k = 0; k < 4; k++)
                    if (b_strb[i][k]) model_mem[int'(idx)][8*k +: 8] = b_data[i][8*k +: 8];
            end
            if (b_last[i] != (i == int'(b_len))) err = 1;
            if (b_burst == 2'b01) a = (a + step) % (longint'(1) << 32);
            else if (b_burst == 2'b10) begin
                base = a - (a % window);
                a    = base + ((a - base + step) % window);
            end
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic run_burst(input logic [1:0] exp_resp);
        int n;
        @(negedge ACLK);
        AWID = b_id; AWADDR = b_addr; AWLEN = b_len; AWSIZE = b_size; AWBURST = b_burst;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) timeout_fail("aw_handshake");
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(b_len); i++) begin
            WID = b_id; WDATA = b_data[i]; WSTRB = b_strb[i]; WLAST = b_last[i];
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
            if (n >= 100) timeout_fail("w_handshake");
            @(negedge ACLK);
            if (b_gap) begin WVALID = 1'b0; @(negedge ACLK); end
        end
        WVALID = 1'b0;
        BREADY = (b_bdelay == 0);
        n = 0;
        while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) timeout_fail("b_valid");
        chk("bid", BID, b_id);
        chk("bresp", BRESP, exp_resp);
        for (int d = 0; d < b_bdelay; d++) begin
            chk("bvalid_hold", BVALID, 1);
            chk("bid_hold", BID, b_id);
            chk("bresp_hold", BRESP, exp_resp);
            chk("awready_during_b", AWREADY, 0);
            chk("wready_during_b", WREADY, 0);
            @(negedge ACLK);
        end
        if (b_bdelay > 0) begin
            BREADY = 1'b1;
            chk("bvalid_at_ready", BVALID, 1);
        end
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bvalid_one_shot", BVALID, 0);
        chk("awready_after_b", AWREADY, 1);
    endtask

    task automatic read_word(input int idx, input logic [31:0] exp, input string name);
        @(negedge ACLK);
        rd_addr = 6'(idx);
        @(negedge ACLK);
        chk(name, rd_data, exp);
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) read_word(i, model_mem[i], $sformatf("mem[%0d]", i));
    endtask

    initial begin
        logic [1:0] mresp;
        int         nb;

        ARESETn = 1'b0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        AWLOCK = 0; AWCACHE = 0; AWPROT = 0; AWVALID = 0;
        WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
        BREADY = 0; rd_addr = 0;

        //            id     addr       len   sz    burst  dbase          strb   bad gap dly resp
        vecs[0]  = '{4'h5, 32'h10,  4'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, -1, 0, 0, 2'b00};
        vecs[1]  = '{4'h3, 32'h20,  4'd3, 3'd2, 2'b01, 32'h1,        4'hF, -1, 1, 0, 2'b00};
        vecs[2]  = '{4'h7, 32'h38,  4'd3, 3'd2, 2'b10, 32'hA,        4'hF, -1, 0, 0, 2'b00};
        vecs[3]  = '{4'h1, 32'h00,  4'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, -1, 0, 0, 2'b00};
        vecs[4]  = '{4'h2, 32'h00,  4'd0, 3'd2, 2'b01, 32'h12345678, 4'h5, -1, 0, 0, 2'b00};
        vecs[5]  = '{4'h9, 32'h100, 4'd0, 3'd2, 2'b01, 32'h55,       4'hF, -1, 0, 0, 2'b10};
        vecs[6]  = '{4'hA, 32'h80,  4'd1, 3'd2, 2'b01, 32'h100,      4'hF,  0, 0, 0, 2'b10};
        vecs[7]  = '{4'hB, 32'h90,  4'd1, 3'd2, 2'b11, 32'h200,      4'hF, -1, 0, 0, 2'b10};
        vecs[8]  = '{4'hC, 32'hA0,  4'd1, 3'd2, 2'b01, 32'h300,      4'hF, -1, 0, 5, 2'b00};
        vecs[9]  = '{4'hD, 32'hC0,  4'd2, 3'd2, 2'b00, 32'h400,      4'h3, -1, 0, 0, 2'b00};
        vecs[10] = '{4'hE, 32'hD0,  4'd0, 3'd3, 2'b01, 32'h500,      4'hF, -1, 0, 0, 2'b10};
        vecs[11] = '{4'hF, 32'hE0,  4'd2, 3'd2, 2'b10, 32'h600,      4'hF, -1, 0, 0, 2'b10};
        vecs[12] = '{4'h4, 32'hB0,  4'd1, 3'd2, 2'b01, 32'h700,      4'hF,  1, 0, 0, 2'b10};
        vecs[13] = '{4'h6, 32'h44,  4'd3, 3'd1, 2'b01, 32'h800,      4'hF, -1, 0, 0, 2'b00};

        repeat (3) @(negedge ACLK);
        chk("reset_awready", AWREADY, 0);
        chk("reset_wready", WREADY, 0);
        chk("reset_bvalid", BVALID, 0);
        chk("reset_bid", BID, 0);
        chk("reset_bresp", BRESP, 0);
        chk("reset_rd_data", rd_data, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("awready_after_reset", AWREADY, 1);

        for (int p = 0; p < 4; p++) begin
            set_burst(4'(p), 32'(p * 64), 4'd15, 3'd2, 2'b01, 32'h0, 4'hF, -1, 0, 0);
            for (int i = 0; i < 16; i++) b_data[i] = $urandom;
            model_apply(mresp);
            run_burst(2'b00);
        end
        check_mem();

        foreach (vecs[v]) begin
            set_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      vecs[v].dbase, vecs[v].strb, vecs[v].bad_last, vecs[v].gap, vecs[v].bdelay);
            model_apply(mresp);
            run_burst(vecs[v].resp);
        end
        read_word(4,  32'hDEADBEEF, "single_beat_word4");
        read_word(8,  32'h1, "incr_word8");
        read_word(9,  32'h2, "incr_word9");
        read_word(10, 32'h3, "incr_word10");
        read_word(11, 32'h4, "incr_word11");
        read_word(14, 32'hA, "wrap_word14");
        read_word(15, 32'hB, "wrap_word15");
        read_word(12, 32'hC, "wrap_word12");
        read_word(13, 32'hD, "wrap_word13");
        read_word(0,  32'hFF34FF78, "strobe_word0");
        read_word(32, 32'h100, "early_wlast_word32");
        read_word(33, 32'h101, "early_wlast_word33");
        check_mem();

        @(negedge ACLK);
        AWID = 4'h8; AWADDR = 32'h60; AWLEN = 4'd7; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWVALID = 1'b1;
        nb = 0;
        while (!AWREADY && nb < 100) begin @(negedge ACLK); nb++; end
        if (nb >= 100) timeout_fail("rst_aw_handshake");
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WDATA = 32'h900 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
            nb = 0;
            while (!WREADY && nb < 100) begin @(negedge ACLK); nb++; end
            if (nb >= 100) timeout_fail("rst_w_handshake");
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("midrst_awready", AWREADY, 0);
        chk("midrst_wready", WREADY, 0);
        chk("midrst_bvalid", BVALID, 0);
        ARESETn = 1'b1;
        BREADY = 1'b1;
        nb = 0;
        repeat (20) begin
            @(negedge ACLK);
            if (BVALID) nb++;
        end
        BREADY = 1'b0;
        chk("midrst_no_b", nb, 0);
        chk("midrst_awready_back", AWREADY, 1);
        model_mem[24] = 32'h900;
        model_mem[25] = 32'h901;
        set_burst(4'h2, 32'h70, 4'd1, 3'd2, 2'b01, 32'hA00, 4'hF, -1, 0, 0);
        model_apply(mresp);
        run_burst(mresp);
        check_mem();

        for (int r = 0; r < 40; r++) begin
            logic [3:0] len;
            len = 4'($urandom_range(0, 15));
            set_burst(4'($urandom), 32'($urandom_range(0, 'h11F)), len,
                      3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'h0, 4'h0,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1,
                      bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            for (int i = 0; i < 16; i++) begin
                b_data[i] = $urandom;
                b_strb[i] = 4'($urandom_range(0, 15));
            end
            model_apply(mresp);
            run_burst(mresp);
        end
        check_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
